nios_debug_scan_master: RTL and testbench

On-chip initiator for the Nios II debug slave's virtual-JTAG interface: it drives the `vji_*` signals that the `sld_virtual_jtag_basic` hub would otherwise drive. Each accepted command performs one IR update, one full DR capture/shift/update and a Run-Test-Idle cycle, then returns the captured DR bits. It sits between a system-clock debug agent (bench sequencer or on-chip monitor) and the debug slave's TCK-side logic, generating TCK as a divided, registered output of `clk`.

---
 rtl/nios_debug_scan_master_pkg.sv | 33 +++
 rtl/nios_debug_scan_master_if.sv | 30 +++
 rtl/nios_debug_scan_master_tck_gen.sv | 44 ++++
 rtl/nios_debug_scan_master.sv | 178 +++++++++++++++++
 tb/tb_nios_debug_scan_master.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_debug_scan_master_pkg.sv
// Shared definitions for the Nios II debug scan master.
// Holds the scan FSM state type, the virtual IR codes understood by the
// Nios II debug slave, the default geometry, and a small state helper.
// No ports: this file is a package imported by the interface and modules.
package nios_debug_scan_pkg;

    localparam int DEF_DR_WIDTH = 38;
    localparam int DEF_IR_WIDTH = 2;
    localparam int DEF_TCK_DIV  = 2;

    // Virtual IR codes selecting the debug slave's DR
    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACE     = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RSP  = 3'd6
    } scan_state_e;

    // True for the states that run TCK (one or more full TCK periods each)
    function automatic logic is_tap_state(input scan_state_e s);
        return (s == ST_UIR) || (s == ST_CDR) || (s == ST_SDR) ||
               (s == ST_UDR) || (s == ST_RTI);
    endfunction

endpackage

// File: rtl/nios_debug_scan_master_if.sv
// Command/response bus between a system-clock debug agent and the scan master.
// Signals:
//   cmd_valid/cmd_ready  command handshake; cmd_ir is the virtual IR value,
//                        cmd_dr the DR data shifted LSB first
//   rsp_valid/rsp_ready  response handshake; rsp_dr holds the captured TDO bits
// Modports: master = debug agent side, slave = scan master side.
interface nios_debug_scan_master_if
    import nios_debug_scan_pkg::*;
#(
    parameter int DR_WIDTH = DEF_DR_WIDTH,
    parameter int IR_WIDTH = DEF_IR_WIDTH
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr
    );
endinterface

// File: rtl/nios_debug_scan_master_tck_gen.sv
// TCK generator for the scan master.
// Ports:
//   i_clk, i_reset_n  system clock, synchronous active-low reset
//   i_en              run TCK; when low TCK is parked low and the divider cleared
//   o_tck             registered TCK, low phase first after enable
//   o_rise_pulse      high in the clk cycle whose closing edge raises TCK
//   o_fall_pulse      high in the clk cycle whose closing edge lowers TCK
module nios_debug_scan_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise_pulse,
    output logic o_fall_pulse
);
    localparam logic [7:0] CNT_LAST = 8'(TCK_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_tck;
    logic       w_toggle;

    assign w_toggle     = i_en && (r_cnt == CNT_LAST);
    assign o_rise_pulse = w_toggle && !r_tck;
    assign o_fall_pulse = w_toggle && r_tck;
    assign o_tck        = r_tck;

    // Half-period divider and TCK register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt <= 8'd0;
            r_tck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= 8'd0;
            r_tck <= 1'b0;
        end else if (w_toggle) begin
            r_cnt <= 8'd0;
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/nios_debug_scan_master.sv
// On-chip virtual-JTAG initiator for the Nios II debug slave.
// Each accepted command performs an IR update, a full DR capture/shift/update
// and one Run-Test-Idle period, then offers the captured DR as a response.
// Ports:
//   i_clk, i_reset_n      system clock, synchronous active-low reset
//   io_bus                command/response bus (slave modport)
//   o_vji_tck, o_vji_tdi  TCK and TDI towards the debug slave
//   i_vji_tdo             TDO from the debug slave
//   o_vji_ir_in           current virtual IR
//   o_vji_uir/cdr/sdr/udr/rti  virtual TAP state flags (at most one high)
module nios_debug_scan_master
    import nios_debug_scan_pkg::*;
#(
    parameter int DR_WIDTH = DEF_DR_WIDTH,
    parameter int IR_WIDTH = DEF_IR_WIDTH,
    parameter int TCK_DIV  = DEF_TCK_DIV
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    nios_debug_scan_master_if.slave io_bus,
    output logic                    o_vji_tck,
    output logic                    o_vji_tdi,
    input  logic                    i_vji_tdo,
    output logic [IR_WIDTH-1:0]     o_vji_ir_in,
    output logic                    o_vji_uir,
    output logic                    o_vji_cdr,
    output logic                    o_vji_sdr,
    output logic                    o_vji_udr,
    output logic                    o_vji_rti
);
    localparam int CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DR_WIDTH - 1);

    scan_state_e         r_state;
    logic                r_start;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [DR_WIDTH-1:0] r_rsp_dr;
    logic [IR_WIDTH-1:0] r_ir_lat;
    logic [IR_WIDTH-1:0] r_ir_in;
    logic [DR_WIDTH-1:0] r_shift;
    logic [DR_WIDTH-1:0] r_capture;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic                r_tdi;
    logic                r_uir, r_cdr, r_sdr, r_udr, r_rti;
    logic                w_en, w_tck, w_rise, w_fall;

    assign w_en = is_tap_state(r_state);

    nios_debug_scan_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_en         (w_en),
        .o_tck        (w_tck),
        .o_rise_pulse (w_rise),
        .o_fall_pulse (w_fall)
    );

    // Scan sequencer: state, TAP flags, shift/capture data and handshakes.
    // Flags and TDI only move on TCK-falling edges (or on UIR entry, where TCK
    // is already low); the TDO sample rides the TCK-rising edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_start     <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_dr    <= '0;
            r_ir_lat    <= '0;
            r_ir_in     <= '0;
            r_shift     <= '0;
            r_capture   <= '0;
            r_bit_cnt   <= '0;
            r_tdi       <= 1'b0;
            r_uir       <= 1'b0;
            r_cdr       <= 1'b0;
            r_sdr       <= 1'b0;
            r_udr       <= 1'b0;
            r_rti       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // One setup cycle after the handshake, then UIR with TCK low
                    if (r_start) begin
                        r_start <= 1'b0;
                        r_state <= ST_UIR;
                        r_uir   <= 1'b1;
                        r_ir_in <= r_ir_lat;
                    end else if (io_bus.cmd_valid && r_cmd_ready) begin
                        r_start     <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_ir_lat    <= io_bus.cmd_ir;
                        r_shift     <= io_bus.cmd_dr;
                    end
                end
                ST_UIR: begin
                    if (w_fall) begin
                        r_state <= ST_CDR;
                        r_uir   <= 1'b0;
                        r_cdr   <= 1'b1;
                    end
                end
                ST_CDR: begin
                    if (w_fall) begin
                        r_state   <= ST_SDR;
                        r_cdr     <= 1'b0;
                        r_sdr     <= 1'b1;
                        r_tdi     <= r_shift[0];
                        r_bit_cnt <= '0;
                    end
                end
                ST_SDR: begin
                    if (w_rise) begin
                        // TDO enters at the MSB so the first bit out ends at bit 0
                        r_capture <= {i_vji_tdo, r_capture[DR_WIDTH-1:1]};
                        r_shift   <= {1'b0, r_shift[DR_WIDTH-1:1]};
                    end else if (w_fall) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= ST_UDR;
                            r_sdr   <= 1'b0;
                            r_udr   <= 1'b1;
                            r_tdi   <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            r_tdi     <= r_shift[0];
                        end
                    end
                end
                ST_UDR: begin
                    if (w_fall) begin
                        r_state <= ST_RTI;
                        r_udr   <= 1'b0;
                        r_rti   <= 1'b1;
                    end
                end
                ST_RTI: begin
                    if (w_fall) begin
                        r_state     <= ST_RSP;
                        r_rti       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dr    <= r_capture;
                    end
                end
                ST_RSP: begin
                    if (io_bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_start     <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_tdi       <= 1'b0;
                    r_uir       <= 1'b0;
                    r_cdr       <= 1'b0;
                    r_sdr       <= 1'b0;
                    r_udr       <= 1'b0;
                    r_rti       <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.cmd_ready = r_cmd_ready;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_dr    = r_rsp_dr;
    assign o_vji_tck        = w_tck;
    assign o_vji_tdi        = r_tdi;
    assign o_vji_ir_in      = r_ir_in;
    assign o_vji_uir        = r_uir;
    assign o_vji_cdr        = r_cdr;
    assign o_vji_sdr        = r_sdr;
    assign o_vji_udr        = r_udr;
    assign o_vji_rti        = r_rti;
endmodule

// File: tb/tb_nios_debug_scan_master.sv
// Bench for nios_debug_scan_master: two instances (TCK_DIV=2 and TCK_DIV=1),
// each driving a behavioural 38-bit debug-slave shift register on its TCK.
module tb_nios_debug_scan_master;
    import nios_debug_scan_pkg::*;

    localparam int DRW = 38;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            cmd_valid [2];
    logic [1:0]      cmd_ir    [2];
    logic [DRW-1:0]  cmd_dr    [2];
    logic            rsp_ready [2];
    logic            cmd_ready [2];
    logic            rsp_valid [2];
    logic [DRW-1:0]  rsp_dr    [2];
    logic            tck [2], tdi [2], tdo [2];
    logic            uir [2], cdr [2], sdr [2], udr [2], rti [2];
    logic [1:0]      ir_in [2];
    logic [DRW-1:0]  preload [2];
    logic [DRW-1:0]  slave_q0 = '0;
    logic [DRW-1:0]  slave_q1 = '0;

    int checks = 0;
    int failures = 0;

    nios_debug_scan_master_if #(.DR_WIDTH(DRW), .IR_WIDTH(2)) bus0 ();
    nios_debug_scan_master_if #(.DR_WIDTH(DRW), .IR_WIDTH(2)) bus1 ();

    assign bus0.cmd_valid = cmd_valid[0];
    assign bus0.cmd_ir    = cmd_ir[0];
    assign bus0.cmd_dr    = cmd_dr[0];
    assign bus0.rsp_ready = rsp_ready[0];
    assign cmd_ready[0]   = bus0.cmd_ready;
    assign rsp_valid[0]   = bus0.rsp_valid;
    assign rsp_dr[0]      = bus0.rsp_dr;
    assign bus1.cmd_valid = cmd_valid[1];
    assign bus1.cmd_ir    = cmd_ir[1];
    assign bus1.cmd_dr    = cmd_dr[1];
    assign bus1.rsp_ready = rsp_ready[1];
    assign cmd_ready[1]   = bus1.cmd_ready;
    assign rsp_valid[1]   = bus1.rsp_valid;
    assign rsp_dr[1]      = bus1.rsp_dr;

    nios_debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(2), .TCK_DIV(2)) dut0 (
        .i_clk(clk), .i_reset_n(reset_n), .io_bus(bus0.slave),
        .o_vji_tck(tck[0]), .o_vji_tdi(tdi[0]), .i_vji_tdo(tdo[0]), .o_vji_ir_in(ir_in[0]),
        .o_vji_uir(uir[0]), .o_vji_cdr(cdr[0]), .o_vji_sdr(sdr[0]), .o_vji_udr(udr[0]), .o_vji_rti(rti[0])
    );

    nios_debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(2), .TCK_DIV(1)) dut1 (
        .i_clk(clk), .i_reset_n(reset_n), .io_bus(bus1.slave),
        .o_vji_tck(tck[1]), .o_vji_tdi(tdi[1]), .i_vji_tdo(tdo[1]), .o_vji_ir_in(ir_in[1]),
        .o_vji_uir(uir[1]), .o_vji_cdr(cdr[1]), .o_vji_sdr(sdr[1]), .o_vji_udr(udr[1]), .o_vji_rti(rti[1])
    );

    // Debug-slave model: capture on rising TCK in CDR, shift in TDI on rising TCK in SDR
    always @(posedge tck[0]) begin
        if (cdr[0]) slave_q0 <= preload[0];
        else if (sdr[0]) slave_q0 <= {tdi[0], slave_q0[DRW-1:1]};
    end
    always @(posedge tck[1]) begin
        if (cdr[1]) slave_q1 <= preload[1];
        else if (sdr[1]) slave_q1 <= {tdi[1], slave_q1[DRW-1:1]};
    end
    assign tdo[0] = slave_q0[0];
    assign tdo[1] = slave_q1[0];

    function automatic int flag_code(input logic [4:0] f);
        case (f)
            5'b00001: return 0;
            5'b00010: return 1;
            5'b00100: return 2;
            5'b01000: return 3;
            5'b10000: return 4;
            default:  return 9;
        endcase
    endfunction

    // Runs one command up to the response becoming valid; collects observations
    task automatic do_scan(input int d, input bit now, input logic [1:0] ir,
                           input logic [DRW-1:0] dr, input logic [DRW-1:0] pre,
                           output int lat, output logic [DRW-1:0] udr_q,
                           output int seq_err, output int proto_err, output int shape_err);
        int q[$];
        int div, run, w;
        logic pt, ptdi;
        logic [4:0] f, pf;
        div = (d == 0) ? 2 : 1;
        lat = -1; udr_q = '0; seq_err = 0; proto_err = 0; shape_err = 0;
        preload[d] = pre;
        if (!now) begin
            @(negedge clk);
            w = 0;
            while (!cmd_ready[d] && w < 20) begin @(negedge clk); w++; end
        end
        if (!cmd_ready[d]) proto_err++;
        cmd_valid[d] = 1'b1; cmd_ir[d] = ir; cmd_dr[d] = dr;
        @(negedge clk);
        cmd_valid[d] = 1'b0; cmd_dr[d] = ~dr; cmd_ir[d] = ~ir;
        pt = 1'b0; ptdi = 1'b0; pf = 5'd0; run = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            f = {rti[d], udr[d], sdr[d], cdr[d], uir[d]};
            if ($countones(f) > 1) proto_err++;
            if (tck[d] && (f != pf || tdi[d] != ptdi)) proto_err++;
            if (f != 5'd0 && cmd_ready[d]) proto_err++;
            if (f == 5'd0 && tck[d]) proto_err++;
            if (pf == 5'd0) run = 1;
            else if (tck[d] == pt) run++;
            else begin
                if (run != div) shape_err++;
                run = 1;
            end
            if (f != 5'd0 && run > div) shape_err++;
            if (tck[d] && !pt) q.push_back(flag_code(f));
            if (udr[d]) udr_q = (d == 0) ? slave_q0 : slave_q1;
            pt = tck[d]; pf = f; ptdi = tdi[d];
            if (rsp_valid[d]) begin lat = n; break; end
        end
        if (q.size() != DRW + 4) seq_err++;
        for (int i = 0; i < q.size() && i < DRW + 4; i++) begin
            if (q[i] != ((i == 0) ? 0 : (i == 1) ? 1 : (i < DRW + 2) ? 2 : (i == DRW + 2) ? 3 : 4))
                seq_err++;
        end
    endtask

    task automatic release_rsp(input int d, input int hold);
        repeat (hold) @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        logic [47:0] obs;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            obs = {rsp_valid[d], rsp_dr[d], tck[d], tdi[d], ir_in[d], uir[d], cdr[d], sdr[d], udr[d], rti[d]};
            checks++;
            if (obs !== 48'd0) begin failures++; $display("FAIL reset_outs dut%0d: got %h expected 0", d, obs); end
            checks++;
            if (cmd_ready[d] !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready dut%0d: got %b expected 1", d, cmd_ready[d]); end
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready[0] !== 1'b1 || tck[0] !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: cmd_ready=%b tck=%b expected 1/0", cmd_ready[0], tck[0]);
        end
    endtask

    task automatic check_scan(input string nm, input int d, input logic [1:0] ir, input logic [DRW-1:0] dr,
                              input logic [DRW-1:0] pre, input bit now);
        int lat, se, pe, sh, exp_lat;
        logic [DRW-1:0] uq;
        exp_lat = (DRW + 4) * 2 * ((d == 0) ? 2 : 1) + 1;
        do_scan(d, now, ir, dr, pre, lat, uq, se, pe, sh);
        checks++;
        if (lat != exp_lat) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", nm, lat, exp_lat); end
        checks++;
        if (rsp_dr[d] !== pre) begin failures++; $display("FAIL %s_rsp_dr: got %h expected %h", nm, rsp_dr[d], pre); end
        checks++;
        if (uq !== dr) begin failures++; $display("FAIL %s_slave_at_udr: got %h expected %h", nm, uq, dr); end
        checks++;
        if (ir_in[d] !== ir) begin failures++; $display("FAIL %s_ir_in: got %h expected %h", nm, ir_in[d], ir); end
        checks++;
        if (se != 0) begin failures++; $display("FAIL %s_flag_order: got %0d errors expected 0", nm, se); end
        checks++;
        if (pe != 0) begin failures++; $display("FAIL %s_protocol: got %0d violations expected 0", nm, pe); end
        checks++;
        if (sh != 0) begin failures++; $display("FAIL %s_tck_shape: got %0d errors expected 0", nm, sh); end
    endtask

    task automatic test_loopback();
        check_scan("loopback", 0, IR_BREAK, 38'h15_DEAD_BEEF, 38'h2A_5A5A_5A5A, 1'b0);
        release_rsp(0, 0);
    endtask

    task automatic test_tck_div1();
        check_scan("div1", 1, IR_BREAK, 38'h15_DEAD_BEEF, 38'h2A_5A5A_5A5A, 1'b0);
        release_rsp(1, 0);
    endtask

    task automatic test_back_pressure_back_to_back();
        logic [DRW-1:0] pre, dr;
        int bad;
        pre = 38'({$urandom(), $urandom()});
        dr  = 38'({$urandom(), $urandom()});
        check_scan("bp", 0, IR_TRACE, dr, pre, 1'b0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b1 || rsp_dr[0] !== pre || cmd_ready[0] !== 1'b0 || tck[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_stall: got %0d bad cycles expected 0", bad); end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
            failures++; $display("FAIL bp_handshake: rsp_valid=%b cmd_ready=%b expected 0/1", rsp_valid[0], cmd_ready[0]);
        end
        pre = 38'({$urandom(), $urandom()});
        dr  = 38'({$urandom(), $urandom()});
        check_scan("b2b", 0, IR_TRACECTRL, dr, pre, 1'b1);
        release_rsp(0, 0);
    endtask

    task automatic test_midscan_reset();
        int rises, udr_seen;
        logic pt;
        bit hit;
        logic [47:0] obs;
        preload[0] = 38'({$urandom(), $urandom()});
        @(negedge clk);
        cmd_valid[0] = 1'b1; cmd_ir[0] = IR_OCIMEM; cmd_dr[0] = 38'({$urandom(), $urandom()});
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        rises = 0; udr_seen = 0; pt = 1'b0; hit = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (udr[0]) udr_seen++;
            if (tck[0] && !pt && sdr[0]) rises++;
            pt = tck[0];
            if (rises == 11) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL midreset_reach_bit10: got %0d sdr bits expected 11", rises); end
        reset_n = 1'b0;
        @(negedge clk);
        obs = {rsp_valid[0], rsp_dr[0], tck[0], tdi[0], ir_in[0], uir[0], cdr[0], sdr[0], udr[0], rti[0]};
        checks++;
        if (obs !== 48'd0 || cmd_ready[0] !== 1'b1) begin
            failures++; $display("FAIL midreset_outs: got %h cmd_ready=%b expected 0/1", obs, cmd_ready[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (udr[0]) udr_seen++;
        end
        checks++;
        if (udr_seen != 0) begin failures++; $display("FAIL midreset_no_udr: got %0d udr cycles expected 0", udr_seen); end
        check_scan("after_reset", 0, IR_BREAK, 38'({$urandom(), $urandom()}), 38'h3F_0F0F_0F0F, 1'b0);
        release_rsp(0, 0);
    endtask

    task automatic test_random();
        int d;
        logic [1:0] ir;
        logic [DRW-1:0] dr, pre;
        for (int k = 0; k < 8; k++) begin
            d   = k % 2;
            ir  = 2'($urandom_range(3, 0));
            dr  = 38'({$urandom(), $urandom()});
            pre = 38'({$urandom(), $urandom()});
            check_scan("random", d, ir, dr, pre, 1'b0);
            release_rsp(d, $urandom_range(5, 0));
            checks++;
            if (rsp_valid[d] !== 1'b0 || cmd_ready[d] !== 1'b1) begin
                failures++; $display("FAIL random_release: rsp_valid=%b cmd_ready=%b expected 0/1", rsp_valid[d], cmd_ready[d]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; cmd_ir[d] = 2'd0; cmd_dr[d] = '0;
            rsp_ready[d] = 1'b0; preload[d] = '0;
        end
        test_reset();
        test_loopback();
        test_tck_div1();
        test_back_pressure_back_to_back();
        test_midscan_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
